// File: rtl/div_issue_ctrl_if.sv
// EX <-> divider-issue controller <-> divider bundle, including the HI/LO write port.
interface div_issue_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic               ex_div_valid;
  logic               ex_div_signed;
  logic [WIDTH-1:0]   ex_rs;
  logic [WIDTH-1:0]   ex_rt;
  logic               flush;
  logic               stall_o;
  logic               div_start;
  logic               div_signed;
  logic [WIDTH-1:0]   div_op1;
  logic [WIDTH-1:0]   div_op2;
  logic [2*WIDTH-1:0] div_result;
  logic               div_ready;
  logic               hilo_we;
  logic [WIDTH-1:0]   hi_wdata;
  logic [WIDTH-1:0]   lo_wdata;

  modport slave (
    input  ex_div_valid, ex_div_signed, ex_rs, ex_rt, flush, div_result, div_ready,
    output stall_o, div_start, div_signed, div_op1, div_op2, hilo_we, hi_wdata, lo_wdata
  );

  modport master (
    output ex_div_valid, ex_div_signed, ex_rs, ex_rt, flush, div_result, div_ready,
    input  stall_o, div_start, div_signed, div_op1, div_op2, hilo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multicycle divider: issues DIV/DIVU, stalls until the
// result returns, writes HI/LO, and drains the divider on flush so it is Free for the next issue.
module div_issue_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  div_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic             signed_q, signed_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      signed_q <= signed_d;
      we_q     <= we_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state and registered-output updates; the write strobe defaults low so it is a single pulse.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    signed_d = signed_q;
    we_d     = 1'b0;
    op1_d    = op1_q;
    op2_d    = op2_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.ex_div_valid && !bus.flush) begin
          signed_d = bus.ex_div_signed;
          op1_d    = bus.ex_rs;
          op2_d    = bus.ex_rt;
          start_d  = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (bus.div_ready && !bus.flush) begin
          hi_d    = bus.div_result[2*WIDTH-1:WIDTH];
          lo_d    = bus.div_result[WIDTH-1:0];
          we_d    = 1'b1;
          start_d = 1'b0;
          state_d = RELEASE;
        end else if (bus.flush) begin
          if (bus.div_ready) begin
            start_d = 1'b0;
            state_d = RELEASE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The divider cannot abort mid-iteration, so start stays high until it reports done.
        if (bus.div_ready) begin
          start_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.stall_o = 1'b0;
    case (state_q)
      IDLE:           bus.stall_o = bus.ex_div_valid && !bus.flush;
      BUSY:           bus.stall_o = !bus.div_ready && !bus.flush;
      DRAIN, RELEASE: bus.stall_o = bus.ex_div_valid && !bus.flush;
      default:        bus.stall_o = 1'b0;
    endcase
  end

  assign bus.div_start  = start_q;
  assign bus.div_signed = signed_q;
  assign bus.div_op1    = op1_q;
  assign bus.div_op2    = op2_q;
  assign bus.hilo_we    = we_q;
  assign bus.hi_wdata   = hi_q;
  assign bus.lo_wdata   = lo_q;

endmodule
